// File: rtl/exp_arbiter.sv
// Round-robin sequencer that shares a single exp LUT unit among NUM_REQ requesters.
// One operand in flight; the result returns tagged with the requester id over valid/ready.
module exp_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN_WIDTH  = 20,
  parameter int OUT_WIDTH = 20,
  parameter int ID_WIDTH  = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic signed [OUT_WIDTH-1:0] resp_data,
  output logic [ID_WIDTH-1:0]         resp_id,
  output logic                        resp_err,
  output logic                        exp_reset,
  output logic                        exp_enable,
  output logic signed [IN_WIDTH-1:0]  exp_data_input,
  input  logic signed [OUT_WIDTH-1:0] exp_data_output,
  input  logic                        exp_done
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] id;
  logic [ID_WIDTH-1:0] sel;
  logic                any_valid;
  logic [CNT_W-1:0]    cnt;
  logic                timeout_hit;

  // Descending scan so the last hit, i.e. the nearest index after rr_ptr, wins.
  always_comb begin
    int idx;
    sel       = rr_ptr;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        sel       = ID_WIDTH'(idx);
        any_valid = 1'b1;
      end
    end
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign req_ready   = (reset && state == IDLE && any_valid) ? (NUM_REQ'(1) << sel) : '0;
  assign exp_enable  = reset && (state == ISSUE);
  assign exp_reset   = !reset || (state == CLEAR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (exp_done || timeout_hit) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset parks the FSM in CLEAR so exp_reset stays high for the first cycle after release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= CLEAR;
      rr_ptr         <= ID_WIDTH'(NUM_REQ - 1);
      id             <= '0;
      cnt            <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      resp_id        <= '0;
      resp_err       <= 1'b0;
      exp_data_input <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_valid) begin
            exp_data_input <= req_data[int'(sel)*IN_WIDTH +: IN_WIDTH];
            id             <= sel;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (exp_done) begin
            resp_data  <= exp_data_output;
            resp_id    <= id;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
          end else if (timeout_hit) begin
            resp_data  <= '0;
            resp_id    <= id;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= id;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exp_arbiter.sv
// Scoreboard bench for exp_arbiter with a behavioural exp unit (LUT path 5 cycles, clamp path 2).
`timescale 1ns/1ps
module tb_exp_arbiter;
  localparam int NUM_REQ = 4, IN_WIDTH = 20, OUT_WIDTH = 20, ID_WIDTH = 2, TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        reset;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*IN_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        resp_valid, resp_ready, resp_err;
  logic [OUT_WIDTH-1:0]        resp_data;
  logic [ID_WIDTH-1:0]         resp_id;
  logic                        exp_reset, exp_enable, exp_done;
  logic [IN_WIDTH-1:0]         exp_data_input;
  logic [OUT_WIDTH-1:0]        exp_data_output;
  logic                        never_done;

  exp_arbiter #(.NUM_REQ(NUM_REQ), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
                .ID_WIDTH(ID_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
    .exp_reset(exp_reset), .exp_enable(exp_enable), .exp_data_input(exp_data_input),
    .exp_data_output(exp_data_output), .exp_done(exp_done));

  function automatic logic is_clamp(input logic [19:0] op);
    int v;
    v = int'($signed(op));
    return (v <= -8192) || (v >= 7168);
  endfunction

  function automatic logic [19:0] exp_model(input logic [19:0] op);
    int v;
    v = int'($signed(op));
    if (v <= -8192) return 20'h00001;
    if (v >= 7168)  return 20'h7FFFF;
    if (v == 0)     return 20'h00400;
    return op + 20'h00400;
  endfunction

  logic       stub_busy;
  logic [3:0] stub_cnt;
  logic [19:0] stub_op;
  always @(posedge clk) begin
    if (exp_reset) begin
      exp_done  <= 1'b0;
      stub_busy <= 1'b0;
      stub_cnt  <= '0;
    end else if (exp_enable) begin
      stub_busy <= !never_done;
      stub_op   <= exp_data_input;
      stub_cnt  <= is_clamp(exp_data_input) ? 4'd0 : 4'd3;
    end else if (stub_busy) begin
      if (stub_cnt == 0) begin
        exp_done        <= 1'b1;
        exp_data_output <= exp_model(stub_op);
        stub_busy       <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1'b1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [OUT_WIDTH-1:0] data;
    logic                 err;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    miscompares++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  int   resp_rise = -1;
  logic prev_valid = 1'b0;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset === 1'b1 && resp_valid === 1'b1 && !prev_valid) resp_rise = cyc;
    prev_valid = (resp_valid === 1'b1);
    if (reset === 1'b1 && resp_valid === 1'b1 && resp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_resp_id", {30'd0, resp_id}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("resp_id", resp_id, e.id);
        check("resp_data", resp_data, e.data);
        check("resp_err", resp_err, e.err);
      end
    end
  end

  int gnt_id[$];
  int gnt_cyc[$];
  int en_cyc[$];
  int rst_cyc[$];

  task automatic clr();
    gnt_id.delete(); gnt_cyc.delete(); en_cyc.delete(); rst_cyc.delete();
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] g;
    @(negedge clk);
    g = req_valid & req_ready;
    for (int i = 0; i < NUM_REQ; i++)
      if (g[i]) begin gnt_id.push_back(i); gnt_cyc.push_back(cyc); end
    if (exp_enable) en_cyc.push_back(cyc);
    if (exp_reset)  rst_cyc.push_back(cyc);
    @(posedge clk); #1;
    req_valid = req_valid & ~g;
  endtask

  task automatic raise(input int i, input logic [19:0] d);
    req_data[i*IN_WIDTH +: IN_WIDTH] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic push(input int id, input logic [19:0] d, input logic err);
    exp_t e;
    e.id = ID_WIDTH'(id); e.data = d; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((sb.size() != 0 || req_valid != 0) && n < limit) begin tick(); n++; end
    if (n >= limit) bound_fail("drain");
    tick(); tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_id"}, resp_id, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_exp_enable"}, exp_enable, 0);
    check({tag, "_exp_data_input"}, exp_data_input, 0);
    check({tag, "_exp_reset"}, exp_reset, 1);
    check({tag, "_req_ready"}, req_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a_cyc, r_cyc;
    int rr_exp[5];
    reset = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b1; never_done = 1'b0;

    // Reset values and release
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b1;
    check("rst_release_exp_reset", exp_reset, 1);
    tick();
    check("rst_idle_exp_reset", exp_reset, 0);

    // Round-robin with all requesters pending
    clr();
    raise(0, 20'h00100); raise(1, 20'h00200); raise(2, 20'h00300); raise(3, 20'h00800);
    push(0, 20'h00500, 0); push(1, 20'h00600, 0); push(2, 20'h00700, 0);
    push(3, 20'h00C00, 0); push(0, 20'h01000, 0);
    rr_exp = '{0, 1, 2, 3, 0};
    n = 0;
    while (gnt_id.size() < 5 && n < 100) begin
      tick(); n++;
      if (n == 1 && gnt_id.size() >= 1) raise(0, 20'h00C00);
    end
    if (n >= 100) bound_fail("rr_grants");
    for (int k = 0; k < 5; k++)
      check("rr_grant", (k < gnt_id.size()) ? gnt_id[k] : 99, rr_exp[k]);
    for (int k = 0; k < 4; k++)
      check("rr_spacing", (k + 1 < gnt_cyc.size()) ? gnt_cyc[k+1] - gnt_cyc[k] : 0, 9);
    drain(60);

    // Single request, operand 0.0
    clr();
    r_cyc = cyc;
    raise(0, 20'h00000);
    push(0, 20'h00400, 0);
    drain(40);
    check("single_grant_cnt", gnt_id.size(), 1);
    check("single_grant_cyc", gnt_cyc[0], r_cyc);
    check("single_enable_cnt", en_cyc.size(), 1);
    check("single_enable_cyc", en_cyc[0], r_cyc + 1);
    check("single_resp_cyc", resp_rise, r_cyc + 7);
    check("single_clear_cnt", rst_cyc.size(), 1);
    check("single_clear_cyc", rst_cyc[0], r_cyc + 8);

    // Clamped operands take the short path
    clr();
    raise(1, 20'hFE000);
    push(1, 20'h00001, 0);
    drain(40);
    check("clamp_lo_grant", gnt_id[0], 1);
    check("clamp_lo_resp_cyc", resp_rise, gnt_cyc[0] + 4);
    clr();
    raise(2, 20'h01C00);
    push(2, 20'h7FFFF, 0);
    drain(40);
    check("clamp_hi_grant", gnt_id[0], 2);
    check("clamp_hi_resp_cyc", resp_rise, gnt_cyc[0] + 4);

    // Backpressure on the response port
    clr();
    resp_ready = 1'b0;
    raise(3, 20'h00040);
    push(3, 20'h00440, 0);
    n = 0;
    while (resp_valid !== 1'b1 && n < 30) begin tick(); n++; end
    if (n >= 30) bound_fail("bp_resp_valid");
    raise(0, 20'h00000);
    push(0, 20'h00400, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("bp_valid", resp_valid, 1);
      check("bp_data", resp_data, 20'h00440);
      check("bp_id", resp_id, 3);
      check("bp_err", resp_err, 0);
      check("bp_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    a_cyc = cyc;
    drain(40);
    check("bp_clear_cyc", rst_cyc[0], a_cyc + 1);
    check("bp_next_grant_id", (gnt_id.size() > 1) ? gnt_id[1] : 99, 0);
    check("bp_next_grant_cyc", (gnt_cyc.size() > 1) ? gnt_cyc[1] : 0, a_cyc + 2);

    // Timeout with an exp unit that never finishes, then a normal operation
    clr();
    never_done = 1'b1;
    raise(1, 20'h00400);
    push(1, 20'h00000, 1);
    drain(120);
    check("to_grant", gnt_id[0], 1);
    check("to_resp_cyc", resp_rise, en_cyc[0] + TIMEOUT + 1);
    never_done = 1'b0;
    clr();
    raise(2, 20'h00000);
    push(2, 20'h00400, 0);
    drain(40);
    check("post_to_grant", gnt_id[0], 2);
    check("post_to_resp_cyc", resp_rise, gnt_cyc[0] + 7);

    // Reset asserted mid-WAIT
    clr();
    raise(3, 20'h00200);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_vals("midrst");
    tick();
    check("midrst2_exp_reset", exp_reset, 1);
    reset = 1'b1;
    raise(0, 20'h00100); raise(2, 20'h00200); raise(3, 20'h00300);
    push(0, 20'h00500, 0); push(2, 20'h00600, 0); push(3, 20'h00700, 0);
    check("midrst_release_exp_reset", exp_reset, 1);
    check("midrst_release_resp_valid", resp_valid, 0);
    clr();
    drain(80);
    check("midrst_first_grant", (gnt_id.size() > 0) ? gnt_id[0] : 99, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
